reg2reg_reduce_pipe: RTL



---
 rtl/reg2reg_pkg.sv | 22 ++
 rtl/reg2reg_pipe_stage.sv | 67 ++++++
 rtl/reg2reg_reduce_pipe.sv | 78 +++++++
 3 files changed

// File: rtl/reg2reg_pkg.sv
// reg2reg_pkg: op encodings and tree/stage sizing helpers for the reduction pipe
package reg2reg_pkg;
    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_XOR  = 2'b10;
    localparam logic [1:0] OP_XNOR = 2'b11;

    function automatic int depth(input int w);
        return $clog2(w);
    endfunction

    function automatic int n_stages(input int d, input int l);
        return (d + l - 1) / l;
    endfunction

    // levels handled by reduction stage k (1-based); the last one may be short
    function automatic int stage_lvls(input int d, input int l, input int k);
        int rem;
        rem = d - (k - 1) * l;
        return rem < l ? rem : l;
    endfunction
endpackage

// File: rtl/reg2reg_pipe_stage.sv
// reg2reg_pipe_stage: reduces LVLS tree levels combinationally, then registers
// the partial vector, op and valid under separate valid/data load enables.
module reg2reg_pipe_stage
    import reg2reg_pkg::*;
#(
    parameter int IW   = 2,
    parameter int LVLS = 1,
    parameter bit LAST = 1'b0,
    localparam int OW  = IW >> LVLS
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ld_i,
    input  logic          dl_i,
    input  logic          vld_i,
    input  logic [1:0]    op_i,
    input  logic [IW-1:0] d_i,
    output logic          vld_o,
    output logic [1:0]    op_o,
    output logic [OW-1:0] q_o
);
    logic [OW-1:0] red, q_d, q_q;
    logic [1:0]    op_q;
    logic          vld_q;

    if (LVLS == 0) begin : g_pass
        assign red = d_i;
    end else begin : g_tree
        for (genvar l = 0; l < LVLS; l++) begin : g_l
            localparam int N = IW >> (l + 1);
            logic [2*N-1:0] a;
            logic [N-1:0]   w;
            if (l == 0) begin : g_in
                assign a = d_i;
            end else begin : g_nx
                assign a = g_l[l-1].w;
            end
            // XNOR rides the tree as XOR; the inversion happens once at the end
            for (genvar j = 0; j < N; j++) begin : g_j
                assign w[j] = op_i == OP_AND ? a[2*j] & a[2*j+1] :
                              op_i == OP_OR  ? a[2*j] | a[2*j+1] :
                                               a[2*j] ^ a[2*j+1];
            end
        end
        assign red = g_l[LVLS-1].w;
    end

    assign q_d = (LAST && op_i == OP_XNOR) ? ~red : red;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= 1'b0;
            op_q  <= '0;
            q_q   <= '0;
        end else begin
            if (ld_i) vld_q <= vld_i;
            if (dl_i) begin
                q_q  <= q_d;
                op_q <= op_i;
            end
        end
    end

    assign vld_o = vld_q;
    assign op_o  = op_q;
    assign q_o   = q_q;
endmodule

// File: rtl/reg2reg_reduce_pipe.sv
// reg2reg_reduce_pipe: capture register plus S tree-reduction stages with a
// global stall, valid/ready handshake and a saturating delivered-result counter.
module reg2reg_reduce_pipe
    import reg2reg_pkg::*;
#(
    parameter int WIDTH       = 2,
    parameter int LVL_PER_STG = 1,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_data,
    output logic [1:0]       out_op,
    output logic [CNT_W-1:0] res_cnt
);
    localparam int D = depth(WIDTH);
    localparam int S = n_stages(D, LVL_PER_STG);

    logic             adv;
    logic [CNT_W-1:0] cnt_d, cnt_q;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // stage 0 is the capture register (no levels); stages 1..S reduce
    for (genvar k = 0; k <= S; k++) begin : g_s
        localparam int SH = k == 0 ? 0 : (k - 1) * LVL_PER_STG;
        localparam int IW = WIDTH >> SH;
        localparam int LV = k == 0 ? 0 : stage_lvls(D, LVL_PER_STG, k);
        localparam int OW = IW >> LV;
        logic [IW-1:0] d;
        logic [1:0]    op_in;
        logic          v_in;
        logic [OW-1:0] q;
        logic [1:0]    op;
        logic          v;
        if (k == 0) begin : g_src
            assign d     = in_data;
            assign op_in = in_op;
            assign v_in  = in_valid;
        end else begin : g_chain
            assign d     = g_s[k-1].q;
            assign op_in = g_s[k-1].op;
            assign v_in  = g_s[k-1].v;
        end
        reg2reg_pipe_stage #(.IW(IW), .LVLS(LV), .LAST(k == S)) u_stg (
            .clk   (clk),
            .rst   (rst),
            .ld_i  (adv),
            .dl_i  (k == 0 ? adv && in_valid : adv),
            .vld_i (v_in),
            .op_i  (op_in),
            .d_i   (d),
            .vld_o (v),
            .op_o  (op),
            .q_o   (q)
        );
    end

    assign out_data  = g_s[S].q;
    assign out_op    = g_s[S].op;
    assign out_valid = g_s[S].v;

    assign cnt_d = (out_valid && out_ready && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign res_cnt = cnt_q;
endmodule
